shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
Multi-bit shift/rotate controller for the ALU's 1-bit shift datapath. It accepts one operation (shift-unit F encoding, operand, shift count, carry-in) through a valid/ready handshake. It then steps the operand one bit per clock for `count` cycles, keeping a registered carry so RCL/RCR chain correctly across steps. The final result and C/Z/N/P flags are presented through a valid/ready result handshake, for the ALU top-level and the register-file writeback.

Parameters:
Width, 16, operand/result width in bits
CntW, 5, shift-count width; any count 0..2^CntW-1 is legal

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  request present
start_ready  output  1  sequencer can accept a request (high only in IDLE)
op  input  3  000 SHL, 001 SHR, 010 SAL, 011 SAR, 100 ROL, 101 ROR, 110 RCL, 111 RCR
a  input  Width  operand
count  input  CntW  number of single-bit steps
cin  input  1  carry-in, used by RCL/RCR and reported as C when count=0
res_valid  output  1  result and flags valid
res_ready  input  1  consumer takes result
result  output  Width  shifted operand
c_flag  output  1  carry flag
z_flag  output  1  1 when result == 0
n_flag  output  1  result[Width-1]
p_flag  output  1  even parity of result (~^result)
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (async, rst_n=0): state IDLE; result=0, c_flag=0, z/n/p=0, res_valid=0, busy=0; start_ready=1 once rst_n deasserts. Reset mid-operation discards the operation with no result.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid: latch op, a into the working register, cin into the carry register, and count into the down-counter.
  - Next state is SHIFT if count != 0, else DONE.
- SHIFT: each cycle applies one step to working reg R and carry register K, then decrements the counter. Step rules:
  - SHL/SAL: {K,R} <= {R,0}
  - SHR: {R,K} <= {0,R}
  - SAR: {R,K} <= {R[W-1],R}
  - ROL: {K,R} <= {R,R[W-1]}
  - ROR: {R,K} <= {R[0],R}
  - RCL: {K,R} <= {R,K}
  - RCR: {R,K} <= {K,R}
  - Go to DONE on the step where the counter reaches 0. Counts above Width are legal and simply execute more steps; e.g. SHL with count>=Width gives 0.
- DONE:
  - res_valid=1; result=R; c_flag=K; z/n/p computed from R.
  - All outputs stay stable while res_ready=0.
  - On res_ready=1, return to IDLE and deassert res_valid next cycle.
- Latency: res_valid rises count+1 cycles after the accepting edge (count=0 gives 1 cycle). Throughput is one operation per count+2 cycles minimum.
- start_valid outside IDLE is ignored (start_ready=0); the inputs are not sampled.
- The op/a/count/cin inputs may change after acceptance without effect.
- Flags are registered with the result; they never glitch while res_valid=1.
- count=0: result=a, c_flag=cin, flags from a.

Test Plan:
1. Reset then idle: rst_n=0 -> all outputs 0, busy=0. After release, start_ready=1.
2. SHL a=0x8001, count=1, cin=0 -> 2 cycles later res_valid=1, result=0x0002, c=1, z=0, n=0, p=0.
3. SAR a=0x8000, count=4 -> result=0xF800, c=0, n=1, p=0 (5 ones), z=0, res_valid 5 cycles after accept. Also ROR a=0x0001, count=1 -> 0x8000, c=1, n=1.
4. RCL a=0x0000, cin=1, count=17 -> full 17-bit ring rotation: result=0x0000, c=1, z=1, p=1, res_valid 18 cycles after accept.
5. count=0: SHL a=0x1234, cin=1 -> result=0x1234, c=1, p=0, z=0, res_valid 1 cycle after accept. Hold res_ready=0 for 3 cycles and pulse start_valid -> outputs unchanged, start_ready=0, second request not accepted.
6. Reset mid-op: ROL a=0x00FF, count=10; drop rst_n on cycle 4 -> outputs immediately 0, state IDLE, no res_valid. A fresh request after release completes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-step shift/rotate sequencer: one bit per clock for `count` steps, result and flags registered on the final step.
// Latency count+1 cycles from accept; the result is held stable in DONE until res_ready, and no new request is taken until then.
module shift_sequencer #(
  parameter int Width = 16,
  parameter int CntW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op,
  input  logic [Width-1:0] a,
  input  logic [CntW-1:0]  count,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [Width-1:0] result,
  output logic             c_flag,
  output logic             z_flag,
  output logic             n_flag,
  output logic             p_flag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [Width-1:0] r_q;
  logic             k_q;
  logic [CntW-1:0]  cnt_q;

  logic [Width-1:0] step_r;
  logic             step_k;
  logic             last_step;
  logic             load_res;
  logic [Width-1:0] res_src;
  logic             res_c;

  // One single-bit step of working register R and carry K.
  always_comb begin
    step_r = r_q;
    step_k = k_q;
    case (op_q)
      3'b000, 3'b010: begin step_k = r_q[Width-1]; step_r = {r_q[Width-2:0], 1'b0};      end
      3'b001:         begin step_k = r_q[0];       step_r = {1'b0, r_q[Width-1:1]};      end
      3'b011:         begin step_k = r_q[0];       step_r = {r_q[Width-1], r_q[Width-1:1]}; end
      3'b100:         begin step_k = r_q[Width-1]; step_r = {r_q[Width-2:0], r_q[Width-1]}; end
      3'b101:         begin step_k = r_q[0];       step_r = {r_q[0], r_q[Width-1:1]};    end
      3'b110:         begin step_k = r_q[Width-1]; step_r = {r_q[Width-2:0], k_q};       end
      default:        begin step_k = r_q[0];       step_r = {k_q, r_q[Width-1:1]};       end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    last_step = 1'b0;
    load_res  = 1'b0;
    res_src   = a;
    res_c     = cin;
    case (state)
      IDLE: begin
        if (start_valid) begin
          state_nxt = (count != '0) ? SHIFT : DONE;
          load_res  = (count == '0);
        end
      end
      SHIFT: begin
        last_step = (cnt_q == CntW'(1));
        res_src   = step_r;
        res_c     = step_k;
        load_res  = last_step;
        if (last_step) state_nxt = DONE;
      end
      default: begin
        if (res_ready) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      r_q   <= '0;
      k_q   <= 1'b0;
      cnt_q <= '0;
    end else if (state == IDLE && start_valid) begin
      op_q  <= op;
      r_q   <= a;
      k_q   <= cin;
      cnt_q <= count;
    end else if (state == SHIFT) begin
      r_q   <= step_r;
      k_q   <= step_k;
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Result and flags only change on the transition into DONE, so they are steady while res_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
      p_flag <= 1'b0;
    end else if (load_res) begin
      result <= res_src;
      c_flag <= res_c;
      z_flag <= (res_src == '0);
      n_flag <= res_src[Width-1];
      p_flag <= ~^res_src;
    end
  end

  assign start_ready = rst_n && (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);

endmodule
